mem_arbiter: RTL

//   Shares the single unified instruction/data memory between two requesters:
//     - port 0: the multicycle CPU (fetch and load/store).
//     - port 1: the program loader/debug port.

---
 rtl/mem_arbiter.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares the unified instruction/data memory between the multicycle CPU
// (port 0) and the program loader/debug port (port 1). One access is in
// flight at a time: the winner's address and write data are registered
// onto the memory side and held while the memory settles. The write strobe
// is pulsed for one cycle on the last wait cycle, read data is captured at
// the same point, and the owner is acked the following cycle.
//
// Build option: define MEM_ARB_ROUND_ROBIN_EN to replace fixed priority
// (with port-1 starvation relief) by round-robin arbitration.

module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic              p0_stall,

    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,

    output logic [DATA_W-1:0] rdata,

    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              busy,
    output logic              grant_id
);

    // Wait counter counts MEM_LAT-1 down to 0; keep at least one bit so the
    // MEM_LAT==1 build still has a legal vector.
    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    // With a single-cycle memory the strobe has to be raised straight out of
    // IDLE because BUSY only lasts one cycle.
    localparam bit WE_FROM_IDLE = (MEM_LAT == 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [CNT_W-1:0]  wait_cnt;
    logic              lat_we;

    logic              any_req;
    logic              pick_p1;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    logic              start;
    logic              last_beat;

    // A transaction starts when IDLE sees any request; the last BUSY cycle
    // is the one where the memory output is valid.
    assign start     = (state == ST_IDLE) && any_req;
    assign last_beat = (state == ST_BUSY) && (wait_cnt == '0);

    // The CPU stalls whenever it is asking and this is not its ack cycle.
    assign p0_stall = p0_req & ~p0_ack;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_grant;

    // Round-robin: on a tie the port that did not win last time goes next.
    always_comb begin
        any_req = p0_req | p1_req;
        if (p0_req && p1_req) begin
            pick_p1 = ~last_grant;
        end else begin
            pick_p1 = p1_req;
        end
    end

    // Remember who won; starts as port 1 so port 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (!reset) begin
            last_grant <= 1'b1;
        end else if (start) begin
            last_grant <= pick_p1;
        end
    end
`else
    localparam int STARVE_W = $clog2(STARVE_MAX + 1);

    logic [STARVE_W-1:0] starve_cnt;
    logic                starved;

    assign starved = (starve_cnt == STARVE_W'(STARVE_MAX));

    // Fixed priority to the CPU, unless the loader has waited through
    // STARVE_MAX CPU grants in a row.
    always_comb begin
        any_req = p0_req | p1_req;
        pick_p1 = p1_req & (~p0_req | starved);
    end

    // Count CPU grants taken while the loader was waiting; clear on a
    // loader grant and saturate at the limit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (start) begin
            if (pick_p1) begin
                starve_cnt <= '0;
            end else if (p1_req && !starved) begin
                starve_cnt <= starve_cnt + STARVE_W'(1);
            end
        end
    end
`endif

    // Steer the winning port's command onto the memory-side capture path.
    always_comb begin
        sel_we    = pick_p1 ? p1_we    : p0_we;
        sel_addr  = pick_p1 ? p1_addr  : p0_addr;
        sel_wdata = pick_p1 ? p1_wdata : p0_wdata;
    end

    // Next-state logic: IDLE -> BUSY for MEM_LAT cycles -> RESP -> IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (any_req) begin
                    state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (wait_cnt == '0) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register; reset abandons whatever transaction is in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Memory wait counter: loaded at grant, counts down while BUSY.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (start) begin
            wait_cnt <= CNT_W'(MEM_LAT - 1);
        end else if ((state == ST_BUSY) && (wait_cnt != '0)) begin
            wait_cnt <= wait_cnt - CNT_W'(1);
        end
    end

    // Capture the winner's command; held stable until the next grant.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            lat_we    <= 1'b0;
            grant_id  <= 1'b0;
        end else if (start) begin
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            lat_we    <= sel_we;
            grant_id  <= pick_p1;
        end
    end

    // Write strobe is high only during the last BUSY cycle of a write, so a
    // reset taken before that cycle means the write never reaches memory.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_we <= 1'b0;
        end else if (start) begin
            mem_we <= WE_FROM_IDLE && sel_we;
        end else if ((state == ST_BUSY) && (wait_cnt == CNT_W'(1))) begin
            mem_we <= lat_we;
        end else begin
            mem_we <= 1'b0;
        end
    end

    // Latch memory read data at the end of the last BUSY cycle; writes
    // leave the previous read value in place.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rdata <= '0;
        end else if (last_beat && !lat_we) begin
            rdata <= mem_rdata;
        end
    end

    // One-cycle completion pulse to whichever port owns the transaction.
    always_ff @(posedge clk) begin
        if (!reset) begin
            p0_ack <= 1'b0;
            p1_ack <= 1'b0;
        end else begin
            p0_ack <= last_beat && !grant_id;
            p1_ack <= last_beat &&  grant_id;
        end
    end

    // Busy covers BUSY and RESP, i.e. every state other than IDLE.
    always_ff @(posedge clk) begin
        if (!reset) begin
            busy <= 1'b0;
        end else begin
            busy <= (state_nxt != ST_IDLE);
        end
    end

endmodule
